// File: rtl/viterbi_pkg.sv
// Shared sizing defaults and FSM state type for the Viterbi traceback slice.
// Optional score outputs are enabled by defining VITERBI_TB_SCORE_EN.
package viterbi_pkg;
  localparam int I_DEF  = 8;
  localparam int N_DEF  = 64;
  localparam int FW_DEF = 16;
  localparam int SW_DEF = $clog2(I_DEF);
  localparam int NW_DEF = $clog2(N_DEF);

  typedef enum logic [1:0] {
    FILL,
    ARGMAX,
    TRACE
  } tb_state_t;
endpackage

// File: rtl/viterbi_psi_mem.sv
// Survivor store: N rows of I back-pointers, full-row write,
// single-entry combinational read.
module viterbi_psi_mem #(
  parameter int I  = 8,
  parameter int N  = 64,
  parameter int SW = $clog2(I),
  parameter int NW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [NW-1:0]         waddr,
  input  logic [I-1:0][SW-1:0]  wdata,
  input  logic [NW-1:0]         raddr,
  input  logic [SW-1:0]         rcol,
  output logic [SW-1:0]         rdata
);
  logic [I-1:0][SW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr][rcol];
endmodule

// File: rtl/viterbi_traceback.sv
// Survivor capture, terminal argmax and backward path streaming.
// Define VITERBI_TB_SCORE_EN to add best_score/best_state outputs.
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int I  = I_DEF,
  parameter int N  = N_DEF,
  parameter int FW = FW_DEF,
  parameter int SW = $clog2(I),
  parameter int NW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  col_valid,
  output logic                  col_ready,
  input  logic [I-1:0][SW-1:0]  psi_col,
  input  logic                  seq_last,
  input  logic [I-1:0][FW-1:0]  delta_final,
  output logic                  path_valid,
  input  logic                  path_ready,
  output logic [SW-1:0]         path_state,
  output logic [NW-1:0]         path_step,
  output logic                  path_last,
  output logic                  ovf
`ifdef VITERBI_TB_SCORE_EN
  ,
  output logic [FW-1:0]         best_score,
  output logic [SW-1:0]         best_state
`endif
);
  tb_state_t state, state_nx;

  logic [NW-1:0]        cnt;
  logic [NW-1:0]        n;
  logic [SW-1:0]        s;
  logic [SW-1:0]        k;
  logic [SW-1:0]        best_idx;
  logic signed [FW-1:0] best_val;
  logic signed [FW-1:0] dl [I];
  logic signed [FW-1:0] k_val;
  logic [SW-1:0]        win_idx;
  logic signed [FW-1:0] win_val;
  logic [SW-1:0]        rd_state;
  logic                 accept;
  logic                 at_cap;
  logic                 last_acc;
  logic                 take;
  logic                 k_end;

  assign col_ready = (state == FILL) && !rst;
  assign accept    = col_valid && col_ready;
  assign at_cap    = (cnt == NW'(N-1));
  assign last_acc  = accept && (seq_last || at_cap);
  assign k_end     = (k == SW'(I-1));

  // Strict compare keeps the lowest index on ties.
  assign k_val   = dl[k];
  assign take    = k_val > best_val;
  assign win_idx = take ? k : best_idx;
  assign win_val = take ? k_val : best_val;

  assign path_valid = (state == TRACE);
  assign path_state = s;
  assign path_step  = n;
  assign path_last  = (state == TRACE) && (n == '0);

  viterbi_psi_mem #(
    .I (I),
    .N (N),
    .SW(SW),
    .NW(NW)
  ) u_mem (
    .clk  (clk),
    .we   (accept),
    .waddr(cnt),
    .wdata(psi_col),
    .raddr(n),
    .rcol (s),
    .rdata(rd_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:    if (last_acc) state_nx = ARGMAX;
      ARGMAX:  if (k_end) state_nx = TRACE;
      TRACE:   if (path_ready && n == '0) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // Terminal delta snapshot carries no reset; it is rewritten per sequence.
  always_ff @(posedge clk) begin
    if (last_acc) begin
      for (int j = 0; j < I; j++) dl[j] <= $signed(delta_final[j]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      n        <= '0;
      s        <= '0;
      k        <= '0;
      best_idx <= '0;
      best_val <= '0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (at_cap && !seq_last) ovf <= 1'b1;
            else if (cnt == '0)      ovf <= 1'b0;
          end
          if (last_acc) begin
            n        <= cnt;
            k        <= '0;
            best_idx <= '0;
            best_val <= $signed(delta_final[0]);
          end
        end
        ARGMAX: begin
          best_idx <= win_idx;
          best_val <= win_val;
          k        <= k + 1'b1;
          if (k_end) s <= win_idx;
        end
        TRACE: begin
          if (path_ready) begin
            if (n != '0) begin
              s <= rd_state;
              n <= n - 1'b1;
            end else begin
              cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VITERBI_TB_SCORE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_score <= '0;
      best_state <= '0;
    end else if (state == ARGMAX && k_end) begin
      best_score <= win_val;
      best_state <= win_idx;
    end
  end
`endif
endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed self-checking bench for viterbi_traceback.
// Score-output checks compile in when VITERBI_TB_SCORE_EN is defined.
module tb_viterbi_traceback;
  localparam int I  = 8;
  localparam int N  = 64;
  localparam int FW = 16;
  localparam int SW = 3;
  localparam int NW = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 col_valid;
  logic                 col_ready;
  logic [I-1:0][SW-1:0] psi_col;
  logic                 seq_last;
  logic [I-1:0][FW-1:0] delta_final;
  logic                 path_valid;
  logic                 path_ready;
  logic [SW-1:0]        path_state;
  logic [NW-1:0]        path_step;
  logic                 path_last;
  logic                 ovf;
`ifdef VITERBI_TB_SCORE_EN
  logic [FW-1:0]        best_score;
  logic [SW-1:0]        best_state;
`endif

  logic [I-1:0][SW-1:0] psi_tab [N];
  logic [I-1:0][FW-1:0] dfin;
  logic [SW-1:0]        exp_state [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  viterbi_traceback dut (
    .clk        (clk),
    .rst        (rst),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .psi_col    (psi_col),
    .seq_last   (seq_last),
    .delta_final(delta_final),
    .path_valid (path_valid),
    .path_ready (path_ready),
    .path_state (path_state),
    .path_step  (path_step),
    .path_last  (path_last),
    .ovf        (ovf)
`ifdef VITERBI_TB_SCORE_EN
    ,
    .best_score (best_score),
    .best_state (best_state)
`endif
  );

  task automatic clear_tabs();
    for (int c = 0; c < N; c++) psi_tab[c] = '0;
    dfin = '0;
  endtask

  task automatic send_seq(input int len, input bit last_flag, input string name);
    int lat;
    for (int c = 0; c < len; c++) begin
      col_valid   = 1'b1;
      psi_col     = psi_tab[c];
      seq_last    = last_flag && (c == len - 1);
      delta_final = dfin;
      n_cmp++;
      if (col_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL %s col_ready col %0d: got %b want 1", name, c, col_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    col_valid = 1'b0;
    seq_last  = 1'b0;
    lat = 0;
    while (!path_valid && lat < 40) begin
      n_cmp++;
      if (col_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s argmax col_ready: got %b want 0", name, col_ready);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_cmp++;
    if (lat != I) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, I);
    end
  endtask

  task automatic collect(input int nb, input int stall_at, input string name);
    int w;
    logic [SW-1:0] hs;
    logic [NW-1:0] ht;
    logic          hl;
    for (int b = 0; b < nb; b++) begin
      w = 0;
      while (!path_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      n_cmp++;
      if (!path_valid || (b > 0 && w != 0)) begin
        n_bad++;
        $display("FAIL %s beat %0d arrival: valid %b gap %0d want valid 1 gap 0",
                 name, b, path_valid, w);
        if (!path_valid) return;
      end
      if (b == stall_at) begin
        hs = path_state;
        ht = path_step;
        hl = path_last;
        path_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_cmp++;
          if ({path_valid, path_state, path_step, path_last} !== {1'b1, hs, ht, hl}) begin
            n_bad++;
            $display("FAIL %s hold beat %0d: got v%b s%0d n%0d l%b want v1 s%0d n%0d l%b",
                     name, b, path_valid, path_state, path_step, path_last, hs, ht, hl);
          end
        end
        path_ready = 1'b1;
      end
      n_cmp++;
      if (path_state !== exp_state[b] || path_step !== NW'(nb - 1 - b) ||
          path_last !== (b == nb - 1) || col_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s beat %0d: got s%0d n%0d l%b cr%b want s%0d n%0d l%b cr0",
                 name, b, path_state, path_step, path_last, col_ready,
                 exp_state[b], nb - 1 - b, b == nb - 1);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (path_valid !== 1'b0 || col_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s end: got valid %b col_ready %b want 0 1", name, path_valid, col_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    col_valid = 1'b0;
    seq_last = 1'b0;
    path_ready = 1'b1;
    psi_col = '0;
    delta_final = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({col_ready, path_valid, path_state, path_step, path_last, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got cr%b v%b s%0d n%0d l%b o%b want all 0",
               col_ready, path_valid, path_state, path_step, path_last, ovf);
    end
`ifdef VITERBI_TB_SCORE_EN
    n_cmp++;
    if (best_score !== '0 || best_state !== '0) begin
      n_bad++;
      $display("FAIL reset score: got %h %0d want 0 0", best_score, best_state);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (col_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset release col_ready: got %b want 1", col_ready);
    end
  endtask

  task automatic test_basic();
    clear_tabs();
    psi_tab[1][3] = 3'd1;
    psi_tab[2][6] = 3'd3;
    for (int j = 0; j < I; j++) dfin[j] = 16'hFFFB;
    dfin[6] = 16'd100;
    exp_state[0] = 3'd6;
    exp_state[1] = 3'd3;
    exp_state[2] = 3'd1;
    send_seq(3, 1'b1, "basic");
    collect(3, -1, "basic");
  endtask

  task automatic test_tie();
    clear_tabs();
    for (int j = 0; j < I; j++) dfin[j] = 16'h0010;
    exp_state[0] = 3'd0;
    send_seq(1, 1'b1, "tie");
`ifdef VITERBI_TB_SCORE_EN
    n_cmp++;
    if (best_score !== 16'h0010 || best_state !== 3'd0) begin
      n_bad++;
      $display("FAIL tie score: got %h %0d want 0010 0", best_score, best_state);
    end
`endif
    collect(1, -1, "tie");
  endtask

  task automatic test_signed();
    clear_tabs();
    for (int j = 0; j < I; j++) psi_tab[1][j] = SW'(j);
    dfin[2] = 16'h7FFF;
    dfin[5] = 16'h8000;
    exp_state[0] = 3'd2;
    exp_state[1] = 3'd2;
    send_seq(2, 1'b1, "signed");
`ifdef VITERBI_TB_SCORE_EN
    n_cmp++;
    if (best_score !== 16'h7FFF || best_state !== 3'd2) begin
      n_bad++;
      $display("FAIL signed score: got %h %0d want 7fff 2", best_score, best_state);
    end
`endif
    collect(2, -1, "signed");
  endtask

  task automatic test_backpressure();
    clear_tabs();
    psi_tab[1][2] = 3'd5;
    psi_tab[2][7] = 3'd2;
    psi_tab[3][1] = 3'd7;
    dfin[1] = 16'd50;
    exp_state[0] = 3'd1;
    exp_state[1] = 3'd7;
    exp_state[2] = 3'd2;
    exp_state[3] = 3'd5;
    send_seq(4, 1'b1, "backpressure");
    collect(4, 1, "backpressure");
  endtask

  task automatic test_overflow();
    clear_tabs();
    for (int c = 0; c < N; c++)
      for (int j = 0; j < I; j++) psi_tab[c][j] = SW'(j);
    dfin[4] = 16'd7;
    for (int b = 0; b < N; b++) exp_state[b] = 3'd4;
    send_seq(N, 1'b0, "overflow");
    n_cmp++;
    if (ovf !== 1'b1 || path_step !== 6'd63) begin
      n_bad++;
      $display("FAIL overflow flag: got ovf %b step %0d want 1 63", ovf, path_step);
    end
    collect(N, -1, "overflow");
  endtask

  task automatic test_ovf_clear();
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf sticky: got %b want 1", ovf);
    end
    clear_tabs();
    dfin[7] = 16'd1;
    exp_state[0] = 3'd7;
    send_seq(1, 1'b1, "ovf_clear");
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf clear: got %b want 0", ovf);
    end
    collect(1, -1, "ovf_clear");
  endtask

  task automatic test_reset_mid_trace();
    clear_tabs();
    for (int c = 0; c < N; c++)
      for (int j = 0; j < I; j++) psi_tab[c][j] = SW'(j);
    dfin[3] = 16'd1;
    send_seq(N, 1'b0, "rst_mid");
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (path_step !== 6'd61 || path_state !== 3'd3 || ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid pre: got n%0d s%0d o%b want n61 s3 o1", path_step, path_state, ovf);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({col_ready, path_valid, path_state, path_step, path_last, ovf} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid async: got cr%b v%b s%0d n%0d l%b o%b want all 0",
               col_ready, path_valid, path_state, path_step, path_last, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (col_ready !== 1'b1 || path_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid release: got cr%b v%b want 1 0", col_ready, path_valid);
    end
    clear_tabs();
    dfin[5] = 16'd9;
    exp_state[0] = 3'd5;
    send_seq(1, 1'b1, "rst_new");
    collect(1, -1, "rst_new");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_signed();
    test_backpressure();
    test_overflow();
    test_ovf_clear();
    test_reset_mid_trace();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
